tensor_operand_loader: RTL and testbench
========================================

Name: tensor_operand_loader

Overview:
- Transmitter side of the TensorUnit operand interface.
- Receives a narrow stream of D_WIDTH-bit IEEE-754 single-precision words over a valid/ready handshake.
- Assembles one M_SIZE x M_SIZE matrix, then one M_SIZE x 1 vector, into the flat buses TensorUnit expects.
- Presents both with matrix/vector valid signals and holds them until TensorUnit's ready signals complete each handshake.

Parameters:
- D_WIDTH, 32, bits per element (IEEE-754 float32; the block does no arithmetic on element values)
- M_SIZE, 4, matrix dimension and vector length; must be >= 2

Ports:
- aclk  in  1  clock, rising edge
- aresetn  in  1  asynchronous active-low reset
- s_word  in  D_WIDTH  streamed element
- s_word_valid  in  1  s_word is valid
- s_word_ready  out  1  loader accepts s_word this cycle
- o_matrix  out  D_WIDTH*M_SIZE*M_SIZE  packed matrix to TensorUnit i_matrix
- o_vector  out  D_WIDTH*M_SIZE  packed vector to TensorUnit i_vector
- o_matrix_is_valid  out  1  drives TensorUnit i_matrix_is_valid
- o_vector_is_valid  out  1  drives TensorUnit i_vector_is_valid
- i_ready_to_accept_matrix  in  1  from TensorUnit o_ready_to_accept_matrix
- i_ready_to_accept_vector  in  1  from TensorUnit o_ready_to_accept_vector
- o_busy  out  1  a frame is partially loaded or being presented

Behaviour:
- Reset (asynchronous, active-low): state goes to LOAD_MATRIX and the word counter is 0. o_matrix and o_vector are all zeros. o_matrix_is_valid, o_vector_is_valid and o_busy are 0. s_word_ready is 1 after reset releases. Reset mid-frame discards partial data, with no further output activity.
- A word transfers on a rising edge where s_word_valid && s_word_ready.
- Stream order: M_SIZE*M_SIZE matrix words in row-major order, then M_SIZE vector words.
- Packing: matrix element (r,c), index k=r*M_SIZE+c, goes to o_matrix[D_WIDTH*(M_SIZE*M_SIZE-1-k) +: D_WIDTH]. The first word lands in the MSB slot.
- Vector element i goes to o_vector[D_WIDTH*(M_SIZE-1-i) +: D_WIDTH].
- FSM states:
  - LOAD_MATRIX: s_word_ready=1. The counter increments per transfer. After transfer M_SIZE*M_SIZE-1, the counter clears and the FSM moves to LOAD_VECTOR.
  - LOAD_VECTOR: s_word_ready=1. After transfer M_SIZE-1, the counter clears and the FSM moves to PRESENT. Both valids rise on the same edge, so they are registered and visible the cycle after the last word.
  - PRESENT: s_word_ready=0.
    - o_matrix_is_valid clears on the edge where it is 1 and i_ready_to_accept_matrix=1. The vector valid clears independently under the same rule with i_ready_to_accept_vector.
    - When both handshakes are done, whether in the same cycle or different cycles, the FSM returns to LOAD_MATRIX on that edge.
    - A valid, once asserted, never drops without its ready.
- o_matrix and o_vector stay stable from valid assertion until the next frame's first word is written. Slots are overwritten only by new transfers; no clearing between frames.
- o_busy is 1 when the counter is non-zero or the state is not LOAD_MATRIX.
- Counter width is $clog2(M_SIZE*M_SIZE). There is no wrap-around beyond the frame length.
- Simultaneous events: s_word_valid asserted in PRESENT is ignored, because ready=0 and the word stays with the source. Ready signals asserted outside PRESENT have no effect.
- Throughput: one word per cycle. Minimum frame period is M_SIZE*M_SIZE+M_SIZE+1 cycles.

Optional Feature:
- Macro: TENSOR_LOADER_FRAME_CHECK_EN.
- When defined:
  - Adds input s_word_last (1) and output o_frame_error (1, reset 0).
  - s_word_last must be 1 exactly on the final vector word.
  - s_word_last=1 on any other transfer sets o_frame_error (sticky until reset) and returns the FSM to LOAD_MATRIX with the counter at 0, discarding the frame with no valids.
  - s_word_last=0 on the final word sets o_frame_error, but the frame is still presented.
- When undefined: these ports do not exist and framing is implied purely by count.

Decomposition:
- Shared package tensor_pkg:
  - state enum (LOAD_MATRIX, LOAD_VECTOR, PRESENT)
  - function for the slot bit offset
  - default D_WIDTH/M_SIZE constants
  - float32 constants used by benches: 1.0=32'h3F800000, 2.0=32'h40000000
- No sub-module; the loader is a single FSM with a counter and two shift-free indexed write ports.

Test Plan:
- Reset: hold aresetn=0 mid LOAD_MATRIX after 5 words -> all outputs 0, s_word_ready=1 after release; the next 20 words form a clean frame.
- Streaming 16 matrix words 1.0..16.0 then vector 1.0,2.0,3.0,4.0 with s_word_valid held high -> o_matrix[511:480]=32'h3F800000, o_matrix[31:0]=32'h41800000, o_vector[127:96]=32'h3F800000. Both valids go high the cycle after word 20, and s_word_ready=0.
- Split handshake: i_ready_to_accept_matrix high 2 cycles before i_ready_to_accept_vector -> matrix valid drops first, vector valid stays high. s_word_ready returns to 1 the cycle after the vector handshake.
- Back-pressure: s_word_valid toggling 1/0 every cycle plus words offered during PRESENT -> no word lost or duplicated; the second frame packs correctly; data is stable while valid.
- With TENSOR_LOADER_FRAME_CHECK_EN: s_word_last on word 10 -> o_frame_error=1, no valids, and the next correctly framed 20 words are presented.
- Back-to-back frames with ready tied high: valid pulses for exactly 1 cycle, frame period 21 cycles.

Source files
------------

// File: rtl/tensor_operand_loader_pkg.sv
// Shared types and constants for the TensorUnit operand loader.
// Optional build macro used by the loader: TENSOR_LOADER_FRAME_CHECK_EN.
package tensor_pkg;

  localparam int D_WIDTH_DEF = 32;
  localparam int M_SIZE_DEF  = 4;

  localparam logic [31:0] FP32_ONE = 32'h3F80_0000;
  localparam logic [31:0] FP32_TWO = 32'h4000_0000;

  typedef enum logic [1:0] {
    LOAD_MATRIX = 2'd0,
    LOAD_VECTOR = 2'd1,
    PRESENT     = 2'd2
  } state_e;

  // Element idx of a packed bus with `slots` entries; element 0 occupies the MSB slot.
  function automatic int unsigned slot_offset(input int unsigned idx,
                                              input int unsigned slots,
                                              input int unsigned width);
    return width * (slots - 32'd1 - idx);
  endfunction

endpackage

// File: rtl/tensor_operand_loader_if.sv
// Stream-in and TensorUnit-out signals of the operand loader.
// s_word_last exists only when TENSOR_LOADER_FRAME_CHECK_EN is defined.
interface tensor_operand_loader_if #(
  parameter int D_WIDTH = tensor_pkg::D_WIDTH_DEF,
  parameter int M_SIZE  = tensor_pkg::M_SIZE_DEF
);
  logic [D_WIDTH-1:0]                s_word;
  logic                              s_word_valid;
  logic                              s_word_ready;
`ifdef TENSOR_LOADER_FRAME_CHECK_EN
  logic                              s_word_last;
`endif
  logic [D_WIDTH*M_SIZE*M_SIZE-1:0]  o_matrix;
  logic [D_WIDTH*M_SIZE-1:0]         o_vector;
  logic                              o_matrix_is_valid;
  logic                              o_vector_is_valid;
  logic                              i_ready_to_accept_matrix;
  logic                              i_ready_to_accept_vector;

`ifdef TENSOR_LOADER_FRAME_CHECK_EN
  modport slave (
    input  s_word, s_word_valid, s_word_last,
    input  i_ready_to_accept_matrix, i_ready_to_accept_vector,
    output s_word_ready, o_matrix, o_vector, o_matrix_is_valid, o_vector_is_valid
  );
  modport master (
    output s_word, s_word_valid, s_word_last,
    output i_ready_to_accept_matrix, i_ready_to_accept_vector,
    input  s_word_ready, o_matrix, o_vector, o_matrix_is_valid, o_vector_is_valid
  );
`else
  modport slave (
    input  s_word, s_word_valid,
    input  i_ready_to_accept_matrix, i_ready_to_accept_vector,
    output s_word_ready, o_matrix, o_vector, o_matrix_is_valid, o_vector_is_valid
  );
  modport master (
    output s_word, s_word_valid,
    output i_ready_to_accept_matrix, i_ready_to_accept_vector,
    input  s_word_ready, o_matrix, o_vector, o_matrix_is_valid, o_vector_is_valid
  );
`endif
endinterface

// File: rtl/tensor_operand_loader.sv
// Streams float32 words into one matrix + one vector frame and presents them to TensorUnit.
// TENSOR_LOADER_FRAME_CHECK_EN adds s_word_last framing and the sticky o_frame_error flag.
module tensor_operand_loader
  import tensor_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int M_SIZE  = M_SIZE_DEF
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  tensor_operand_loader_if.slave  bus,
  output logic                    o_busy
`ifdef TENSOR_LOADER_FRAME_CHECK_EN
  ,
  output logic                    o_frame_error
`endif
);

  localparam int MM    = M_SIZE * M_SIZE;
  localparam int CW    = $clog2(MM);
  localparam int MAT_W = D_WIDTH * MM;
  localparam int VEC_W = D_WIDTH * M_SIZE;
  localparam logic [CW-1:0] CNT_M_LAST = CW'(MM - 1);
  localparam logic [CW-1:0] CNT_V_LAST = CW'(M_SIZE - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [MAT_W-1:0] matrix_q, matrix_d;
  logic [VEC_W-1:0] vector_q, vector_d;
  logic             mvalid_q, mvalid_d;
  logic             vvalid_q, vvalid_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;

  logic xfer_s, is_final_s, early_last_s, late_miss_s, m_done_s, v_done_s;

  assign xfer_s     = bus.s_word_valid && ready_q;
  assign is_final_s = (state_q == LOAD_VECTOR) && (cnt_q == CNT_V_LAST);
  assign m_done_s   = !mvalid_q || bus.i_ready_to_accept_matrix;
  assign v_done_s   = !vvalid_q || bus.i_ready_to_accept_vector;

`ifdef TENSOR_LOADER_FRAME_CHECK_EN
  // A premature last aborts the frame; a missing last on the final word only flags it.
  assign early_last_s = xfer_s && bus.s_word_last && !is_final_s;
  assign late_miss_s  = xfer_s && !bus.s_word_last && is_final_s;
  assign o_frame_error = frame_err_q;
`else
  assign early_last_s = 1'b0;
  assign late_miss_s  = 1'b0;
`endif

  // State, counter, data and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= LOAD_MATRIX;
      cnt_q       <= '0;
      matrix_q    <= '0;
      vector_q    <= '0;
      mvalid_q    <= 1'b0;
      vvalid_q    <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      matrix_q    <= matrix_d;
      vector_q    <= vector_d;
      mvalid_q    <= mvalid_d;
      vvalid_q    <= vvalid_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state and word-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOAD_MATRIX: begin
        if (!xfer_s) begin
          cnt_d = cnt_q;
        end else if (early_last_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_M_LAST) begin
          state_d = LOAD_VECTOR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOAD_VECTOR: begin
        if (!xfer_s) begin
          cnt_d = cnt_q;
        end else if (early_last_s) begin
          state_d = LOAD_MATRIX;
          cnt_d   = '0;
        end else if (is_final_s) begin
          state_d = PRESENT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESENT: begin
        if (m_done_s && v_done_s) begin
          state_d = LOAD_MATRIX;
        end else begin
          state_d = PRESENT;
        end
      end
      default: begin
        state_d = LOAD_MATRIX;
        cnt_d   = '0;
      end
    endcase
  end

  // Slot writes, handshake valids, ready/busy and error flag.
  always_comb begin
    matrix_d    = matrix_q;
    vector_d    = vector_q;
    mvalid_d    = mvalid_q;
    vvalid_d    = vvalid_q;
    frame_err_d = frame_err_q | early_last_s | late_miss_s;
    case (state_q)
      LOAD_MATRIX: begin
        if (xfer_s) begin
          matrix_d[slot_offset(32'(cnt_q), MM, D_WIDTH) +: D_WIDTH] = bus.s_word;
        end else begin
          matrix_d = matrix_q;
        end
      end
      LOAD_VECTOR: begin
        if (xfer_s) begin
          vector_d[slot_offset(32'(cnt_q), M_SIZE, D_WIDTH) +: D_WIDTH] = bus.s_word;
          mvalid_d = is_final_s;
          vvalid_d = is_final_s;
        end else begin
          vector_d = vector_q;
        end
      end
      PRESENT: begin
        if (mvalid_q && bus.i_ready_to_accept_matrix) begin
          mvalid_d = 1'b0;
        end else begin
          mvalid_d = mvalid_q;
        end
        if (vvalid_q && bus.i_ready_to_accept_vector) begin
          vvalid_d = 1'b0;
        end else begin
          vvalid_d = vvalid_q;
        end
      end
      default: begin
        mvalid_d = 1'b0;
        vvalid_d = 1'b0;
      end
    endcase
    ready_d = (state_d != PRESENT);
    busy_d  = (cnt_d != '0) || (state_d != LOAD_MATRIX);
  end

  assign bus.s_word_ready      = ready_q;
  assign bus.o_matrix          = matrix_q;
  assign bus.o_vector          = vector_q;
  assign bus.o_matrix_is_valid = mvalid_q;
  assign bus.o_vector_is_valid = vvalid_q;
  assign o_busy                = busy_q;

endmodule

// File: tb/tb_tensor_operand_loader.sv
// Scoreboard bench for tensor_operand_loader; frame-check scenario runs only with
// TENSOR_LOADER_FRAME_CHECK_EN defined.
module tb_tensor_operand_loader;
  import tensor_pkg::*;

  localparam int D  = 32;
  localparam int M  = 4;
  localparam int MM = M * M;
  localparam int NW = MM + M;
  localparam int MW = D * MM;
  localparam int VW = D * M;

  logic aclk = 1'b0;
  logic aresetn;
  logic busy;
`ifdef TENSOR_LOADER_FRAME_CHECK_EN
  logic frame_err;
`endif

  always #5 aclk = ~aclk;

  tensor_operand_loader_if #(.D_WIDTH(D), .M_SIZE(M)) bus ();

  tensor_operand_loader #(.D_WIDTH(D), .M_SIZE(M)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus),
    .o_busy  (busy)
`ifdef TENSOR_LOADER_FRAME_CHECK_EN
    ,
    .o_frame_error (frame_err)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [MW-1:0] exp_m_q [$];
  logic [VW-1:0] exp_v_q [$];
  logic [31:0]   frame_w [NW];
  logic [MW-1:0] cur_m;
  logic [VW-1:0] cur_v;

  function automatic logic [31:0] fp_of(input int n);
    case (n)
      1:  return 32'h3F80_0000;  2:  return 32'h4000_0000;
      3:  return 32'h4040_0000;  4:  return 32'h4080_0000;
      5:  return 32'h40A0_0000;  6:  return 32'h40C0_0000;
      7:  return 32'h40E0_0000;  8:  return 32'h4100_0000;
      9:  return 32'h4110_0000;  10: return 32'h4120_0000;
      11: return 32'h4130_0000;  12: return 32'h4140_0000;
      13: return 32'h4150_0000;  14: return 32'h4160_0000;
      15: return 32'h4170_0000;  16: return 32'h4180_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic build_seq();
    for (int k = 0; k < MM; k++) frame_w[k] = fp_of(k + 1);
    for (int i = 0; i < M; i++)  frame_w[MM + i] = fp_of(i + 1);
  endtask

  task automatic build_rand();
    for (int k = 0; k < NW; k++) frame_w[k] = $urandom;
  endtask

  task automatic push_expected();
    logic [MW-1:0] em;
    logic [VW-1:0] ev;
    em = '0;
    ev = '0;
    for (int k = 0; k < MM; k++) em[D*(MM-1-k) +: D] = frame_w[k];
    for (int i = 0; i < M; i++)  ev[D*(M-1-i) +: D]  = frame_w[MM + i];
    exp_m_q.push_back(em);
    exp_v_q.push_back(ev);
  endtask

  // Holds the word on the bus until the loader takes it (bounded).
  task automatic send_word(input logic [31:0] w, input logic last);
    logic seen;
    bit   done;
    done = 1'b0;
    bus.s_word       = w;
    bus.s_word_valid = 1'b1;
`ifdef TENSOR_LOADER_FRAME_CHECK_EN
    bus.s_word_last  = last;
`endif
    for (int t = 0; t < 100 && !done; t++) begin
      seen = bus.s_word_ready;
      tick();
      if (seen) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %h not accepted within 100 cycles, required acceptance", w);
    end
  endtask

  task automatic stream_frame(input bit gap);
    push_expected();
    for (int k = 0; k < NW; k++) begin
      send_word(frame_w[k], (k == NW - 1));
      if (gap && k != NW - 1) begin
        bus.s_word_valid = 1'b0;
        bus.s_word       = 32'hDEAD_BEEF;
        tick();
      end
    end
    bus.s_word_valid = 1'b0;
  endtask

  task automatic check_presented(input string tag);
    checks++;
    if (bus.o_matrix_is_valid !== 1'b1 || bus.o_vector_is_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valids: got m=%b v=%b, required 1/1", tag,
               bus.o_matrix_is_valid, bus.o_vector_is_valid);
    end
    checks++;
    if (bus.s_word_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_busy: got ready=%b busy=%b, required 0/1", tag, bus.s_word_ready, busy);
    end
    cur_m = exp_m_q.pop_front();
    cur_v = exp_v_q.pop_front();
    checks++;
    if (bus.o_matrix !== cur_m) begin
      errors++;
      $display("FAIL %s_matrix: got %h, required %h", tag, bus.o_matrix, cur_m);
    end
    checks++;
    if (bus.o_vector !== cur_v) begin
      errors++;
      $display("FAIL %s_vector: got %h, required %h", tag, bus.o_vector, cur_v);
    end
  endtask

  task automatic handshake_both();
    bus.i_ready_to_accept_matrix = 1'b1;
    bus.i_ready_to_accept_vector = 1'b1;
    tick();
    bus.i_ready_to_accept_matrix = 1'b0;
    bus.i_ready_to_accept_vector = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    checks++;
    if (bus.o_matrix !== '0 || bus.o_vector !== '0 || bus.o_matrix_is_valid !== 1'b0 ||
        bus.o_vector_is_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got mvalid=%b vvalid=%b busy=%b m_nonzero=%b v_nonzero=%b, required all 0",
               tag, bus.o_matrix_is_valid, bus.o_vector_is_valid, busy,
               |bus.o_matrix, |bus.o_vector);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    check_idle_zero("reset_state");
    aresetn = 1'b1;
    tick();
    checks++;
    if (bus.s_word_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b, required 1/0", bus.s_word_ready, busy);
    end
    build_rand();
    for (int k = 0; k < 5; k++) send_word(frame_w[k], 1'b0);
    bus.s_word_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL partial_busy: got %b, required 1", busy);
    end
    aresetn = 1'b0;
    #2;
    check_idle_zero("mid_frame_reset");
    tick();
    aresetn = 1'b1;
    tick();
    checks++;
    if (bus.s_word_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release: got ready=%b busy=%b, required 1/0", bus.s_word_ready, busy);
    end
  endtask

  task automatic test_stream();
    build_seq();
    stream_frame(1'b0);
    checks++;
    if (bus.o_matrix[511:480] !== FP32_ONE || bus.o_matrix[31:0] !== 32'h4180_0000 ||
        bus.o_vector[127:96] !== FP32_ONE || bus.o_vector[95:64] !== FP32_TWO) begin
      errors++;
      $display("FAIL stream_slots: got m_msb=%h m_lsb=%h v0=%h v1=%h, required 3f800000 41800000 3f800000 40000000",
               bus.o_matrix[511:480], bus.o_matrix[31:0], bus.o_vector[127:96], bus.o_vector[95:64]);
    end
    check_presented("stream");
  endtask

  task automatic test_split_handshake();
    bus.i_ready_to_accept_matrix = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (bus.o_matrix_is_valid !== 1'b0 || bus.o_vector_is_valid !== 1'b1 ||
          bus.s_word_ready !== 1'b0 || bus.o_vector !== cur_v) begin
        errors++;
        $display("FAIL split_matrix_first: cycle %0d got m=%b v=%b ready=%b, required 0/1/0 with vector held",
                 c, bus.o_matrix_is_valid, bus.o_vector_is_valid, bus.s_word_ready);
      end
    end
    bus.i_ready_to_accept_vector = 1'b1;
    tick();
    bus.i_ready_to_accept_matrix = 1'b0;
    bus.i_ready_to_accept_vector = 1'b0;
    checks++;
    if (bus.o_vector_is_valid !== 1'b0 || bus.s_word_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL split_vector_done: got v=%b ready=%b busy=%b, required 0/1/0",
               bus.o_vector_is_valid, bus.s_word_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    build_rand();
    stream_frame(1'b1);
    check_presented("gapped");
    build_rand();
    bus.s_word       = frame_w[0];
    bus.s_word_valid = 1'b1;
`ifdef TENSOR_LOADER_FRAME_CHECK_EN
    bus.s_word_last  = 1'b0;
`endif
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.s_word_ready !== 1'b0 || bus.o_matrix_is_valid !== 1'b1 ||
          bus.o_vector_is_valid !== 1'b1 || bus.o_matrix !== cur_m || bus.o_vector !== cur_v) begin
        errors++;
        $display("FAIL present_hold: cycle %0d got ready=%b m=%b v=%b, required 0/1/1 with data stable",
                 c, bus.s_word_ready, bus.o_matrix_is_valid, bus.o_vector_is_valid);
      end
    end
    bus.s_word_valid = 1'b0;
    handshake_both();
    checks++;
    if (bus.o_matrix !== cur_m || bus.s_word_ready !== 1'b1 || bus.o_matrix_is_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_handshake_stable: got ready=%b m=%b matrix_changed=%b, required 1/0/0",
               bus.s_word_ready, bus.o_matrix_is_valid, bus.o_matrix !== cur_m);
    end
    stream_frame(1'b0);
    check_presented("after_offer");
    handshake_both();
  endtask

  task automatic test_frame_check();
`ifdef TENSOR_LOADER_FRAME_CHECK_EN
    build_rand();
    for (int k = 0; k < 10; k++) send_word(frame_w[k], (k == 9));
    bus.s_word_valid = 1'b0;
    checks++;
    if (frame_err !== 1'b1 || busy !== 1'b0 || bus.o_matrix_is_valid !== 1'b0 ||
        bus.o_vector_is_valid !== 1'b0 || bus.s_word_ready !== 1'b1) begin
      errors++;
      $display("FAIL early_last_abort: got err=%b busy=%b m=%b v=%b ready=%b, required 1/0/0/0/1",
               frame_err, busy, bus.o_matrix_is_valid, bus.o_vector_is_valid, bus.s_word_ready);
    end
    tick();
    checks++;
    if (bus.o_matrix_is_valid !== 1'b0 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_valid: got m=%b err=%b, required 0/1", bus.o_matrix_is_valid, frame_err);
    end
    build_rand();
    stream_frame(1'b0);
    check_presented("after_abort");
    handshake_both();
`endif
  endtask

  task automatic test_back_to_back();
    int   seen;
    int   last_rise;
    int   cyc;
    logic prev_v;
    bus.i_ready_to_accept_matrix = 1'b1;
    bus.i_ready_to_accept_vector = 1'b1;
    fork
      begin
        build_rand();
        stream_frame(1'b0);
        build_rand();
        stream_frame(1'b0);
      end
      begin
        seen = 0;
        last_rise = 0;
        prev_v = 1'b0;
        cyc = 0;
        while (seen < 2 && cyc < 150) begin
          tick();
          cyc++;
          if (bus.o_matrix_is_valid === 1'b1) begin
            checks++;
            if (prev_v === 1'b1) begin
              errors++;
              $display("FAIL b2b_pulse_width: valid high 2 cycles at cycle %0d, required 1-cycle pulse", cyc);
            end
            if (seen > 0) begin
              checks++;
              if (cyc - last_rise != NW + 1) begin
                errors++;
                $display("FAIL b2b_period: got %0d cycles, required %0d", cyc - last_rise, NW + 1);
              end
            end
            cur_m = exp_m_q.pop_front();
            cur_v = exp_v_q.pop_front();
            checks++;
            if (bus.o_matrix !== cur_m || bus.o_vector !== cur_v || bus.o_vector_is_valid !== 1'b1) begin
              errors++;
              $display("FAIL b2b_data: frame %0d vvalid=%b matrix_ok=%b vector_ok=%b, required 1/1/1",
                       seen, bus.o_vector_is_valid, bus.o_matrix === cur_m, bus.o_vector === cur_v);
            end
            last_rise = cyc;
            seen++;
          end
          prev_v = bus.o_matrix_is_valid;
        end
        if (seen < 2) begin
          checks++;
          errors++;
          $display("FAIL b2b_timeout: got %0d frames, required 2", seen);
        end
        tick();
        checks++;
        if (bus.o_matrix_is_valid !== 1'b0 || bus.o_vector_is_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_pulse_end: got m=%b v=%b, required 0/0",
                   bus.o_matrix_is_valid, bus.o_vector_is_valid);
        end
      end
    join
    bus.i_ready_to_accept_matrix = 1'b0;
    bus.i_ready_to_accept_vector = 1'b0;
  endtask

  initial begin
    bus.s_word                   = 32'h0000_0000;
    bus.s_word_valid             = 1'b0;
    bus.i_ready_to_accept_matrix = 1'b0;
    bus.i_ready_to_accept_vector = 1'b0;
`ifdef TENSOR_LOADER_FRAME_CHECK_EN
    bus.s_word_last              = 1'b0;
`endif
    test_reset();
    test_stream();
    test_split_handshake();
    test_backpressure();
    test_frame_check();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
